// File: rtl/gsim_pkg.sv
// gsim_pkg
// Shared definitions for the Gauss-Seidel solver slice: the unloader FSM
// state encoding and the default sizing constants used by the x register
// file, the x unloader and the solver top.
//
// Contents:
//   gsim_state_e  - unloader FSM states (IDLE, RUN, DRAIN, DONE)
//   N_X_DEF       - default number of unknowns (power of two)
//   X_W_DEF       - default x word width (signed Q16.16)
//   ITER_NUM_DEF  - default number of solver iterations before capture
package gsim_pkg;

  localparam int N_X_DEF      = 16;
  localparam int X_W_DEF      = 32;
  localparam int ITER_NUM_DEF = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } gsim_state_e;

endpackage

// File: rtl/gsim_x_buffer.sv
// gsim_x_buffer
// N_X x X_W register array holding the captured x vector. One synchronous
// write port and a combinational read port. When GSIM_UNLOADER_CONV_EN is
// defined, the word currently stored at the write address is also exposed so
// the unloader can compare each new x value against the previous iteration.
//
// Ports:
//   clk_in    - clock
//   we        - write enable
//   waddr     - write address (x index)
//   wdata     - write data
//   raddr     - read address
//   rdata     - read data (combinational from the array)
//   wold      - (GSIM_UNLOADER_CONV_EN only) current contents at waddr
//
// Configuration macro: GSIM_UNLOADER_CONV_EN
module gsim_x_buffer
  import gsim_pkg::*;
#(
  parameter int N_X = N_X_DEF,
  parameter int X_W = X_W_DEF
) (
  input  logic                   clk_in,
  input  logic                   we,
  input  logic [$clog2(N_X)-1:0] waddr,
  input  logic [X_W-1:0]         wdata,
  input  logic [$clog2(N_X)-1:0] raddr,
  output logic [X_W-1:0]         rdata
`ifdef GSIM_UNLOADER_CONV_EN
  ,
  output logic [X_W-1:0]         wold
`endif
);

  logic [X_W-1:0] mem_q [N_X];
  logic [X_W-1:0] mem_d [N_X];

  // The array carries no reset: its contents are only meaningful after a
  // capture has completed, and the unloader never reads it before that.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

`ifdef GSIM_UNLOADER_CONV_EN
  // Old word is read before the write lands, which is what the convergence
  // compare needs.
  assign wold = mem_q[waddr];
`endif

endmodule

// File: rtl/gsim_x_unloader.sv
// gsim_x_unloader
// Result-side reader for the Gauss-Seidel solver. Follows the register file's
// start strobe to count solver iterations, captures the N_X x values written
// back during the final iteration into gsim_x_buffer, then drains them to the
// host in index order over a valid/ready stream.
//
// Ports:
//   clk_in        - clock
//   rst_in        - synchronous active-high reset
//   start_in      - register-file start strobe, held high while the solver runs
//   x_in          - x value written back this cycle
//   out_ready_in  - host accepts x_out
//   out_valid     - x_out holds a result
//   x_out         - result word, index order 0..N_X-1 (0 when not valid)
//   iter_out      - completed iterations
//   done_out      - all N_X results accepted (sticky until reset)
//
// Configuration macro: GSIM_UNLOADER_CONV_EN
//   Defined   : buffer written every iteration; if a whole iteration (iter>=1)
//               rewrites identical values, drain early.
//   Undefined : capture only in the final iteration, no compare logic.
module gsim_x_unloader
  import gsim_pkg::*;
#(
  parameter int N_X      = N_X_DEF,
  parameter int X_W      = X_W_DEF,
  parameter int ITER_NUM = ITER_NUM_DEF
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            start_in,
  input  logic [X_W-1:0]                  x_in,
  input  logic                            out_ready_in,
  output logic                            out_valid,
  output logic [X_W-1:0]                  x_out,
  output logic [$clog2(ITER_NUM+1)-1:0]   iter_out,
  output logic                            done_out
);

  localparam int AW = $clog2(N_X);
  localparam int IW = $clog2(ITER_NUM + 1);

  localparam logic [AW-1:0] IDX_LAST  = AW'(N_X - 1);
  localparam logic [IW-1:0] ITER_LAST = IW'(ITER_NUM - 1);
  localparam logic [IW-1:0] ITER_MAX  = IW'(ITER_NUM);

  gsim_state_e    state_q, state_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [IW-1:0]  iter_q, iter_d;
  logic           out_valid_q, out_valid_d;
  logic           done_q, done_d;

  logic           buf_we;
  logic [X_W-1:0] buf_rdata;
  logic           last_idx;
  logic           last_iter;
  logic           end_capture;
  logic [IW-1:0]  iter_inc;

`ifdef GSIM_UNLOADER_CONV_EN
  logic           match_q, match_d;
  logic           iter_match;
  logic [X_W-1:0] buf_old;
`endif

  gsim_x_buffer #(
    .N_X (N_X),
    .X_W (X_W)
  ) u_buf (
    .clk_in (clk_in),
    .we     (buf_we),
    .waddr  (idx_q),
    .wdata  (x_in),
    .raddr  (rd_ptr_q),
    .rdata  (buf_rdata)
`ifdef GSIM_UNLOADER_CONV_EN
    ,
    .wold   (buf_old)
`endif
  );

  assign last_idx  = (idx_q == IDX_LAST);
  assign last_iter = (iter_q == ITER_LAST);
  assign iter_inc  = (iter_q == ITER_MAX) ? iter_q : iter_q + 1'b1;

`ifdef GSIM_UNLOADER_CONV_EN
  // Running "everything matched so far" flag; index 0 starts a new iteration
  // so the previous iteration's result is not carried over.
  assign iter_match  = ((idx_q == '0) || match_q) && (buf_old == x_in);
  // The iter>=1 guard keeps the first pass, which compares against stale
  // buffer contents, from ever triggering an early exit.
  assign end_capture = last_idx && (last_iter || (iter_match && (iter_q != '0)));
`else
  assign end_capture = last_idx && last_iter;
`endif

  // Next-state logic. IDLE always holds idx/iter at zero, so the first start
  // sample can share the RUN path as index 0 of iteration 0.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    iter_d      = iter_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    done_d      = done_q;
    buf_we      = 1'b0;
`ifdef GSIM_UNLOADER_CONV_EN
    match_d     = match_q;
`endif

    case (state_q)
      IDLE, RUN: begin
        if (start_in) begin
`ifdef GSIM_UNLOADER_CONV_EN
          buf_we  = 1'b1;
          match_d = iter_match;
`else
          buf_we  = last_iter;
`endif
          state_d = RUN;
          idx_d   = idx_q + 1'b1;
          if (last_idx) begin
            iter_d = iter_inc;
          end
          if (end_capture) begin
            state_d     = DRAIN;
            out_valid_d = 1'b1;
            rd_ptr_d    = '0;
          end
        end else if (state_q == RUN) begin
          // Solver aborted: forget progress and wait for a fresh start.
          state_d = IDLE;
          idx_d   = '0;
          iter_d  = '0;
`ifdef GSIM_UNLOADER_CONV_EN
          match_d = 1'b0;
`endif
        end
      end

      DRAIN: begin
        if (out_ready_in) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          if (rd_ptr_q == IDX_LAST) begin
            state_d     = DONE;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
          end
        end
      end

      DONE: begin
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      iter_q      <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef GSIM_UNLOADER_CONV_EN
      match_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      iter_q      <= iter_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
`ifdef GSIM_UNLOADER_CONV_EN
      match_q     <= match_d;
`endif
    end
  end

  // Read pointer is registered and the buffer is frozen during DRAIN, so
  // x_out is stable under backpressure. Masked to zero outside DRAIN.
  assign x_out     = out_valid_q ? buf_rdata : '0;
  assign out_valid = out_valid_q;
  assign iter_out  = iter_q;
  assign done_out  = done_q;

endmodule
